// File: rtl/mp_add_pkg.sv
// ============================================================================
// Module  : mp_add_pkg
// Brief   : Shared types and helpers for the multi-precision adder sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mp_add_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Slice counter needs at least one bit, even for a single-word operand.
  function automatic int cnt_width(input int words);
    return (words <= 1) ? 1 : $clog2(words);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mp_add_seq_rca.sv
// ============================================================================
// Module  : mp_add_seq_rca
// Brief   : WIDTH-bit ripple-carry adder slice.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_add_seq_rca #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             carry_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] w_c;

  assign w_c[0] = carry_i;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign sum_o[i]   = a_i[i] ^ b_i[i] ^ w_c[i];
    assign w_c[i+1]   = (a_i[i] & b_i[i]) | (w_c[i] & (a_i[i] ^ b_i[i]));
  end

  assign carry_o = w_c[WIDTH];

endmodule

`default_nettype wire

// File: rtl/mp_add_seq.sv
// ============================================================================
// Module  : mp_add_seq
// Brief   : Multi-precision adder; one WIDTH-bit slice per cycle, LS word
//           first. Optional subtract mode via macro MP_ADD_SUB_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int WORDS = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   start_valid_i,
  output logic                   start_ready_o,
  input  logic [WIDTH*WORDS-1:0] a_i,
  input  logic [WIDTH*WORDS-1:0] b_i,
  input  logic                   carry_i,
`ifdef MP_ADD_SUB_EN
  input  logic                   sub_i,
`endif
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic [WIDTH*WORDS-1:0] sum_o,
  output logic                   carry_o,
  output logic                   busy_o
);

  localparam int N     = WIDTH * WORDS;
  localparam int CNT_W = cnt_width(WORDS);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WORDS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic [N-1:0]     r_a_sh;
  logic [N-1:0]     r_b_sh;
  logic [N-1:0]     r_sum;
  logic             r_carry_out;

  logic             w_start;
  logic             w_last;
  logic [WIDTH-1:0] w_slice_sum;
  logic             w_slice_carry;
  logic [N+WIDTH-1:0] w_sum_cat;
  logic [N-1:0]     w_b_load;
  logic             w_cin_load;

`ifdef MP_ADD_SUB_EN
  // Subtraction as A + ~B + 1; carry_i is deliberately ignored here.
  assign w_b_load   = sub_i ? ~b_i : b_i;
  assign w_cin_load = sub_i ? 1'b1 : carry_i;
`else
  assign w_b_load   = b_i;
  assign w_cin_load = carry_i;
`endif

  assign w_start   = start_valid_i && (r_state == ST_IDLE);
  assign w_last    = (r_cnt == C_LAST);
  assign w_sum_cat = {w_slice_sum, r_sum};

  mp_add_seq_rca #(
    .WIDTH (WIDTH)
  ) u_rca (
    .a_i     (r_a_sh[WIDTH-1:0]),
    .b_i     (r_b_sh[WIDTH-1:0]),
    .carry_i (r_carry),
    .sum_o   (w_slice_sum),
    .carry_o (w_slice_carry)
  );

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    start_ready_o = 1'b0;
    res_valid_o   = 1'b0;
    busy_o        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        start_ready_o = 1'b1;
        if (start_valid_i) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        busy_o = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy_o      = 1'b1;
        res_valid_o = 1'b1;
        if (res_ready_i) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_a_sh      <= '0;
      r_b_sh      <= '0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
    end else if (w_start) begin
      r_cnt   <= '0;
      r_carry <= w_cin_load;
      r_a_sh  <= a_i;
      r_b_sh  <= w_b_load;
    end else if (r_state == ST_RUN) begin
      // Each slice enters at the top; after WORDS slices the LS word is at bit 0.
      r_sum   <= w_sum_cat[N+WIDTH-1:WIDTH];
      r_a_sh  <= r_a_sh >> WIDTH;
      r_b_sh  <= r_b_sh >> WIDTH;
      r_carry <= w_slice_carry;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) r_carry_out <= w_slice_carry;
    end
  end

  assign sum_o   = r_sum;
  assign carry_o = r_carry_out;

endmodule

`default_nettype wire

// File: tb/tb_mp_add_seq.sv
// ============================================================================
// Module  : tb_mp_add_seq
// Brief   : Scoreboard bench for mp_add_seq (WORDS=4 plus a WORDS=1 instance).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mp_add_seq;

  typedef struct packed {
    logic [15:0] sum;
    logic        c;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [15:0] sum;
  logic        carry;
  logic        busy;

  logic        s1_valid = 1'b0;
  logic        s1_ready;
  logic [3:0]  s1_a = '0;
  logic [3:0]  s1_b = '0;
  logic        s1_cin = 1'b0;
  logic        s1_res_valid;
  logic [3:0]  s1_sum;
  logic        s1_carry;
  logic        s1_busy;

  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mp_add_seq #(.WIDTH(4), .WORDS(4)) u_dut (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_valid_i (start_valid),
    .start_ready_o (start_ready),
    .a_i           (a),
    .b_i           (b),
    .carry_i       (cin),
`ifdef MP_ADD_SUB_EN
    .sub_i         (sub),
`endif
    .res_valid_o   (res_valid),
    .res_ready_i   (res_ready),
    .sum_o         (sum),
    .carry_o       (carry),
    .busy_o        (busy)
  );

  mp_add_seq #(.WIDTH(4), .WORDS(1)) u_dut1 (
    .clk_i         (clk),
    .rst_n_i       (rst_n),
    .start_valid_i (s1_valid),
    .start_ready_o (s1_ready),
    .a_i           (s1_a),
    .b_i           (s1_b),
    .carry_i       (s1_cin),
`ifdef MP_ADD_SUB_EN
    .sub_i         (1'b0),
`endif
    .res_valid_o   (s1_res_valid),
    .res_ready_i   (1'b1),
    .sum_o         (s1_sum),
    .carry_o       (s1_carry),
    .busy_o        (s1_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start_ready();
    int n = 0;
    while (!start_ready && n < 20) begin
      tick();
      n++;
    end
    check("start_ready_wait", {31'd0, start_ready}, 32'd1);
  endtask

  // Issue one command, push its expected result and measure handshake-to-valid latency.
  task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic ic,
                       input logic isub, input logic [15:0] esum, input logic ec);
    int n = 0;
    wait_start_ready();
    a = ia; b = ib; cin = ic; sub = isub; start_valid = 1'b1;
    exp_q.push_back('{sum: esum, c: ec});
    tick();
    start_valid = 1'b0;
    while (!res_valid && n < 20) begin
      tick();
      n++;
    end
    check("latency", n, 4);
  endtask

  // Scoreboard monitor: one comparison per consumed result.
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%h expected=none", sum);
      end else begin
        mon_e = exp_q.pop_front();
        check("sum", {16'd0, sum}, {16'd0, mon_e.sum});
        check("carry", {31'd0, carry}, {31'd0, mon_e.c});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_start_ready", {31'd0, start_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_sum", {16'd0, sum}, 32'd0);
    check("rst_carry", {31'd0, carry}, 32'd0);

    issue(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    issue(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1);
    issue(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);

    // Backpressure: hold DONE for 6 cycles and try to slip in a command.
    tick();
    res_ready = 1'b0;
    issue(16'h0F0F, 16'h00F1, 1'b1, 1'b0, 16'h1001, 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("hold_valid", {31'd0, res_valid}, 32'd1);
      check("hold_sum", {16'd0, sum}, 32'h1001);
      check("hold_carry", {31'd0, carry}, 32'd0);
      check("hold_start_ready", {31'd0, start_ready}, 32'd0);
      if (i == 2) begin
        a = 16'hAAAA; b = 16'hAAAA; cin = 1'b1; start_valid = 1'b1;
      end else begin
        start_valid = 1'b0;
      end
      tick();
    end
    start_valid = 1'b0;
    res_ready = 1'b1;
    tick();
    check("release_start_ready", {31'd0, start_ready}, 32'd1);
    check("release_valid", {31'd0, res_valid}, 32'd0);
    check("release_busy", {31'd0, busy}, 32'd0);
    check("retain_sum", {16'd0, sum}, 32'h1001);

    // Reset during the second RUN cycle.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start_valid = 1'b1;
    tick();
    start_valid = 1'b0;
    tick();
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_valid", {31'd0, res_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_sum", {16'd0, sum}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    issue(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0);

`ifdef MP_ADD_SUB_EN
    issue(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    issue(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    sub = 1'b0;
`endif

    // Single-word instance: RUN lasts exactly one cycle.
    s1_a = 4'h9; s1_b = 4'h8; s1_cin = 1'b1; s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    check("w1_busy", {31'd0, s1_busy}, 32'd1);
    check("w1_not_yet_valid", {31'd0, s1_res_valid}, 32'd0);
    tick();
    check("w1_valid", {31'd0, s1_res_valid}, 32'd1);
    check("w1_sum", {28'd0, s1_sum}, 32'h2);
    check("w1_carry", {31'd0, s1_carry}, 32'd1);
    tick();
    check("w1_idle", {31'd0, s1_ready}, 32'd1);
    s1_a = 4'h3; s1_b = 4'h4; s1_cin = 1'b0; s1_valid = 1'b1;
    tick();
    s1_valid = 1'b0;
    tick();
    check("w1_valid2", {31'd0, s1_res_valid}, 32'd1);
    check("w1_sum2", {28'd0, s1_sum}, 32'h7);
    check("w1_carry2", {31'd0, s1_carry}, 32'd0);

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
